// File: rtl/layer_mv_stream.sv
// Streaming dense layer y = act(W*x + b) with P parallel MAC lanes; W, b and x arrive over the input stream.
// Optional macro LAYER_MV_SAT_EN clamps each result to the signed T-bit range instead of wrapping it.
module layer_mv_stream #(
  parameter int M    = 16,
  parameter int N    = 8,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int FRAC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  input  logic                load_cfg,
  input  logic                relu_en,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out,
  output logic                busy
);

  localparam int ROWS = M / P;
  localparam int A    = 2 * T + $clog2(N);
  localparam int NW   = (N > 1) ? $clog2(N) : 1;
  localparam int LW   = (P > 1) ? $clog2(P) : 1;
  localparam int SW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WAW  = (ROWS * N > 1) ? $clog2(ROWS * N) : 1;
  localparam int CW   = $clog2(N + 2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_LOAD_X  = 3'd3;
  localparam logic [2:0] S_COMPUTE = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;

  localparam logic [NW-1:0] LAST_COL    = NW'(N - 1);
  localparam logic [LW-1:0] LAST_LANE   = LW'(P - 1);
  localparam logic [SW-1:0] LAST_SLOT   = SW'(ROWS - 1);
  localparam logic [CW-1:0] CYC_FIRST   = CW'(1);
  localparam logic [CW-1:0] CYC_ACC_END = CW'(N);
  localparam logic [CW-1:0] CYC_DONE    = CW'(N + 1);

  if (M % P != 0) begin : g_bad_cfg
    $error("layer_mv_stream: M (%0d) must be a multiple of P (%0d)", M, P);
  end

  logic [2:0]    state;
  logic [NW-1:0] col_cnt;
  logic [LW-1:0] lane_cnt;
  logic [SW-1:0] slot_cnt;
  logic [SW-1:0] grp;
  logic [LW-1:0] out_lane;
  logic [CW-1:0] cyc;
  logic          relu_q;

  logic signed [T-1:0] w_ram [P][ROWS*N];
  logic signed [T-1:0] b_ram [P][ROWS];
  logic signed [T-1:0] x_ram [N];
  logic signed [T-1:0] w_q   [P];
  logic signed [T-1:0] b_q   [P];
  logic signed [T-1:0] x_q;

  logic signed [2*T-1:0] prod_full [P];
  logic signed [2*T-1:0] prod_sh   [P];
  logic signed [A-1:0]   prod_ext  [P];
  logic signed [A-1:0]   b_ext     [P];
  logic signed [A-1:0]   acc       [P];
  logic signed [T-1:0]   res       [P];

  logic           accept, w_we, b_we, x_we;
  logic           col_wrap, lane_wrap, slot_wrap, last_w, last_b;
  logic [WAW-1:0] w_wr_addr, w_rd_addr;
  logic [NW-1:0]  rd_col;

  assign s_ready = !reset && (state == S_IDLE || state == S_LOAD_W ||
                              state == S_LOAD_B || state == S_LOAD_X);
  assign accept  = s_valid && s_ready;
  assign busy    = (state != S_IDLE);

  assign w_we = accept && ((state == S_IDLE && load_cfg) || state == S_LOAD_W);
  assign b_we = accept && (state == S_LOAD_B);
  assign x_we = accept && ((state == S_IDLE && !load_cfg) || state == S_LOAD_X);

  assign col_wrap  = (col_cnt == LAST_COL);
  assign lane_wrap = (lane_cnt == LAST_LANE);
  assign slot_wrap = (slot_cnt == LAST_SLOT);
  assign last_w    = col_wrap && lane_wrap && slot_wrap;
  assign last_b    = lane_wrap && slot_wrap;

  // Row i lives in lane i%P at slot i/P, so counters advance column, then lane, then slot.
  assign w_wr_addr = WAW'(slot_cnt) * WAW'(N) + WAW'(col_cnt);
  assign rd_col    = (cyc < CYC_ACC_END) ? NW'(cyc) : '0;
  assign w_rd_addr = WAW'(grp) * WAW'(N) + WAW'(rd_col);

  // NOTE: every variable in this block is assigned on every pass, so no latch can be inferred.
  always_comb begin
    for (int l = 0; l < P; l++) begin
      prod_full[l] = (2*T)'(w_q[l]) * (2*T)'(x_q);
      prod_sh[l]   = prod_full[l] >>> FRAC;
      prod_ext[l]  = A'(prod_sh[l]);
      b_ext[l]     = A'(b_q[l]);
    end
  end

`ifdef LAYER_MV_SAT_EN
  localparam logic signed [A-1:0] SAT_MAX = {{(A-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [A-1:0] SAT_MIN = {{(A-T+1){1'b1}}, {(T-1){1'b0}}};
`endif

  function automatic logic signed [T-1:0] narrow(input logic signed [A-1:0] a, input logic relu);
    logic signed [A-1:0] v;
    v = (relu && a < 0) ? '0 : a;
`ifdef LAYER_MV_SAT_EN
    if (v > SAT_MAX)      narrow = {1'b0, {(T-1){1'b1}}};
    else if (v < SAT_MIN) narrow = {1'b1, {(T-1){1'b0}}};
    else                  narrow = v[T-1:0];
`else
    narrow = v[T-1:0];
`endif
  endfunction

  // NOTE: RAMs carry no reset; contents survive reset so loaded weights remain usable.
  always_ff @(posedge clk) begin
    if (w_we) w_ram[lane_cnt][w_wr_addr] <= data_in;
    if (b_we) b_ram[lane_cnt][slot_cnt]  <= data_in;
    if (x_we) x_ram[col_cnt]             <= data_in;
    for (int l = 0; l < P; l++) begin
      w_q[l] <= w_ram[l][w_rd_addr];
      b_q[l] <= b_ram[l][grp];
    end
    x_q <= x_ram[rd_col];
  end

  // NOTE: sequential state uses <= so every register samples values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      col_cnt  <= '0;
      lane_cnt <= '0;
      slot_cnt <= '0;
      grp      <= '0;
      out_lane <= '0;
      cyc      <= '0;
      relu_q   <= 1'b0;
      m_valid  <= 1'b0;
      data_out <= '0;
      for (int l = 0; l < P; l++) begin
        acc[l] <= '0;
        res[l] <= '0;
      end
    end else begin
      if (w_we) begin
        col_cnt <= col_wrap ? '0 : col_cnt + 1'b1;
        if (col_wrap) begin
          lane_cnt <= lane_wrap ? '0 : lane_cnt + 1'b1;
          if (lane_wrap) slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
        end
      end
      if (b_we) begin
        lane_cnt <= lane_wrap ? '0 : lane_cnt + 1'b1;
        if (lane_wrap) slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      end
      if (x_we) col_cnt <= col_wrap ? '0 : col_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (accept) begin
            relu_q <= relu_en;
            cyc    <= '0;
            grp    <= '0;
            if (load_cfg) state <= last_w ? S_LOAD_B : S_LOAD_W;
            else          state <= col_wrap ? S_COMPUTE : S_LOAD_X;
          end
        end
        S_LOAD_W: if (accept && last_w)   state <= S_LOAD_B;
        S_LOAD_B: if (accept && last_b)   state <= S_IDLE;
        S_LOAD_X: if (accept && col_wrap) state <= S_COMPUTE;
        S_COMPUTE: begin
          // Read data for element k arrives one cycle after its address, hence the offset by one.
          cyc <= cyc + 1'b1;
          for (int l = 0; l < P; l++) begin
            if (cyc == CYC_FIRST)
              acc[l] <= b_ext[l] + prod_ext[l];
            else if (cyc != '0 && cyc <= CYC_ACC_END)
              acc[l] <= acc[l] + prod_ext[l];
          end
          if (cyc == CYC_DONE) begin
            for (int l = 0; l < P; l++) res[l] <= narrow(acc[l], relu_q);
            data_out <= narrow(acc[0], relu_q);
            m_valid  <= 1'b1;
            out_lane <= '0;
            cyc      <= '0;
            state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            if (out_lane == LAST_LANE) begin
              m_valid  <= 1'b0;
              out_lane <= '0;
              if (grp == LAST_SLOT) begin
                grp   <= '0;
                state <= S_IDLE;
              end else begin
                grp   <= grp + 1'b1;
                state <= S_COMPUTE;
              end
            end else begin
              out_lane <= out_lane + 1'b1;
              data_out <= res[out_lane + 1'b1];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mv_stream.sv
// Directed bench for layer_mv_stream: three instances (FRAC=0, FRAC=2, single-row saturation case)
// share one stimulus bus; sel picks which instance is driven and observed.
module tb_layer_mv_stream;

  localparam int TIMEOUT = 60;

  logic clk = 1'b0;
  logic reset;
  logic s_valid, load_cfg, relu_en, m_ready;
  logic signed [15:0] data_in;
  int sel;

  logic s_v [3];
  logic s_r [3];
  logic m_r [3];
  logic m_v [3];
  logic bsy [3];
  logic signed [15:0] d_o [3];

  logic cur_s_ready, cur_m_valid, cur_busy;
  logic signed [15:0] cur_data_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_gate
    assign s_v[i] = s_valid && (sel == i);
    assign m_r[i] = m_ready && (sel == i);
  end

  assign cur_s_ready  = s_r[sel];
  assign cur_m_valid  = m_v[sel];
  assign cur_busy     = bsy[sel];
  assign cur_data_out = d_o[sel];

  layer_mv_stream #(.M(4), .N(2), .T(16), .P(2), .FRAC(0)) dut_a (
    .clk(clk), .reset(reset), .s_valid(s_v[0]), .s_ready(s_r[0]), .data_in(data_in),
    .load_cfg(load_cfg), .relu_en(relu_en), .m_valid(m_v[0]), .m_ready(m_r[0]),
    .data_out(d_o[0]), .busy(bsy[0]));

  layer_mv_stream #(.M(4), .N(2), .T(16), .P(2), .FRAC(2)) dut_b (
    .clk(clk), .reset(reset), .s_valid(s_v[1]), .s_ready(s_r[1]), .data_in(data_in),
    .load_cfg(load_cfg), .relu_en(relu_en), .m_valid(m_v[1]), .m_ready(m_r[1]),
    .data_out(d_o[1]), .busy(bsy[1]));

  layer_mv_stream #(.M(1), .N(2), .T(16), .P(1), .FRAC(0)) dut_c (
    .clk(clk), .reset(reset), .s_valid(s_v[2]), .s_ready(s_r[2]), .data_in(data_in),
    .load_cfg(load_cfg), .relu_en(relu_en), .m_valid(m_v[2]), .m_ready(m_r[2]),
    .data_out(d_o[2]), .busy(bsy[2]));

  typedef struct packed {
    bit relu;
    int x0;
    int x1;
    int y0;
    int y1;
    int y2;
    int y3;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_word(input int v, input logic lc, input logic re);
    int t;
    t = 0;
    s_valid  = 1'b1;
    data_in  = v[15:0];
    load_cfg = lc;
    relu_en  = re;
    while (!cur_s_ready && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    if (!cur_s_ready) check("s_ready_wait", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic recv_word(output int v, output bit ok);
    int t;
    t = 0;
    m_ready = 1'b1;
    while (!cur_m_valid && t < TIMEOUT) begin
      @(negedge clk);
      t++;
    end
    ok = cur_m_valid;
    v  = int'(cur_data_out);
    if (ok) @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 1;
    while (!cur_m_valid && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic load_params(input int w[8], input int nw, input int b[4], input int nb);
    // load_cfg/relu_en after the first word are deliberately scrambled; the block must ignore them
    for (int i = 0; i < nw; i++) begin
      send_word(w[i], (i == 0) ? 1'b1 : 1'(i & 1) , 1'(i & 1));
      if (i == 2) repeat (3) @(negedge clk);
    end
    for (int i = 0; i < nb; i++) send_word(b[i], 1'b0, 1'b1);
  endtask

  task automatic run_x(input int x0, input int x1, input logic relu);
    send_word(x0, 1'b0, relu);
    send_word(x1, 1'b1, ~relu);
  endtask

  task automatic collect(input string name, input int exp[4], input int n);
    int v;
    bit ok;
    for (int i = 0; i < n; i++) begin
      recv_word(v, ok);
      if (!ok) check($sformatf("%s_y%0d_valid", name, i), 0, 1);
      else     check($sformatf("%s_y%0d", name, i), v, exp[i]);
    end
  endtask

  initial begin
    vec_t vecs [8];
    int wa [8];
    int ba [4];
    int ea [4];
    int lat;
    int v;
    bit ok;

    vecs[0] = '{1'b1,   2,   3,  9,  18,   0,   7};
    vecs[1] = '{1'b0,   2,   3,  9,  18,  -5,   7};
    vecs[2] = '{1'b0,   0,   0,  1,   0,   0,  -3};
    vecs[3] = '{1'b1,   0,   0,  1,   0,   0,   0};
    vecs[4] = '{1'b0,  -1,   1,  2,   1,   0,  -8};
    vecs[5] = '{1'b1,  -2,  -3,  0,   0,   5,   0};
    vecs[6] = '{1'b0,  -2,  -3, -7, -18,   5, -13};
    vecs[7] = '{1'b0, 100, -50,  1, 100, -50, 497};

    sel = 0; reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    load_cfg = 1'b0; relu_en = 1'b0; data_in = '0;

    #3;
    check("rst_s_ready", int'(cur_s_ready), 0);
    check("rst_m_valid", int'(cur_m_valid), 0);
    check("rst_busy", int'(cur_busy), 0);
    check("rst_data_out", int'(cur_data_out), 0);
    #9 reset = 1'b0;
    @(negedge clk);
    check("idle_s_ready", int'(cur_s_ready), 1);

    // Instance A: W=[[1,2],[3,4],[-1,-1],[5,0]], b=[1,0,0,-3]
    wa = '{1, 2, 3, 4, -1, -1, 5, 0};
    ba = '{1, 0, 0, -3};
    load_params(wa, 8, ba, 4);
    check("load_a_busy", int'(cur_busy), 0);
    check("load_a_no_out", int'(cur_m_valid), 0);

    for (int i = 0; i < 8; i++) begin
      run_x(vecs[i].x0, vecs[i].x1, vecs[i].relu);
      if (i == 0) begin
        wait_valid(lat);
        check("latency", lat, 5);
      end
      ea = '{vecs[i].y0, vecs[i].y1, vecs[i].y2, vecs[i].y3};
      collect($sformatf("vec%0d", i), ea, 4);
      check($sformatf("vec%0d_done_busy", i), int'(cur_busy), 0);
    end

    // Backpressure on the first output word
    run_x(2, 3, 1'b1);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), int'(cur_m_valid), 1);
      check($sformatf("bp%0d_data", k), int'(cur_data_out), 9);
      @(negedge clk);
    end
    ea = '{9, 18, 0, 7};
    collect("bp", ea, 4);
    check("bp_after_valid", int'(cur_m_valid), 0);
    check("bp_after_busy", int'(cur_busy), 0);

    // Instance B (FRAC=2): each product is shifted before accumulation
    sel = 1;
    wa = '{4, 4, -1, 0, 1, 1, 0, -1};
    ba = '{0, 0, 0, 0};
    load_params(wa, 8, ba, 4);
    run_x(3, 5, 1'b0);
    ea = '{8, -1, 1, -2};
    collect("frac2", ea, 4);

    // Instance C (1x2): narrowing of a result outside the 16-bit range
    sel = 2;
    wa = '{32767, 32767, 0, 0, 0, 0, 0, 0};
    ba = '{0, 0, 0, 0};
    load_params(wa, 2, ba, 1);
    run_x(2, 2, 1'b0);
`ifdef LAYER_MV_SAT_EN
    ea = '{32767, 0, 0, 0};
`else
    ea = '{-4, 0, 0, 0};
`endif
    collect("sat_pos", ea, 1);
    run_x(-2, -2, 1'b0);
`ifdef LAYER_MV_SAT_EN
    ea = '{-32768, 0, 0, 0};
`else
    ea = '{4, 0, 0, 0};
`endif
    collect("sat_neg", ea, 1);

    // Asynchronous reset in the middle of OUT, then recompute on retained weights
    sel = 0;
    run_x(2, 3, 1'b1);
    recv_word(v, ok);
    check("rst_mid_first", ok ? v : -9999, 9);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_m_valid", int'(cur_m_valid), 0);
    check("rst_mid_busy", int'(cur_busy), 0);
    #4 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_partial%0d", k), int'(cur_m_valid), 0);
    end
    run_x(2, 3, 1'b1);
    ea = '{9, 18, 0, 7};
    collect("post_rst", ea, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
